// File: rtl/seq_divider_if.sv
// Handshake bundle between the issue stage (master) and the sequential divider (slave).
// Operands travel with in_valid/in_ready; results with out_valid/out_ready.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle via a WIDTH+1-bit trial subtraction.
// Divide-by-zero short-circuits to DONE with quotient = all ones and remainder = dividend.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] divisor_q;

  logic             accept;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign accept = (state_q == IDLE) && bus.in_valid;

  // Subtraction done as add-of-complement; trial[WIDTH] set means the subtraction borrowed.
  assign shifted = {rem_q, q_q[WIDTH-1]};
  assign trial   = shifted + {1'b1, ~divisor_q} + (WIDTH+1)'(1);

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no path leaves a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          cnt_d = '0;
          if (bus.divisor != '0) begin
            q_d     = bus.dividend;
            rem_d   = '0;
            dbz_d   = 1'b0;
            state_d = CALC;
          end else begin
            q_d     = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // NOTE: the divisor copy is pure datapath, only read after a load, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      divisor_q <= bus.divisor;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = q_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
